// File: rtl/banked_mat_ram.sv
// ---------------------------------------------------------------------------
// banked_mat_ram
//
// Banked matrix operand storage. Holds NUM_BANKS banks of 2**ADDR_LEN words
// each, with one synchronous write port and one registered read port. After
// reset, or after a clr pulse, a built-in clear engine zeroes one row of every
// bank per clock. The array is only accessible once that sweep has finished.
//
// Optional feature macro: MATRAM_BYPASS_EN
//   defined   - a same-cycle read and write to the same address returns
//               wr_data on Q (write-first forwarding)
//   undefined - a same-cycle read and write to the same address returns the
//               previously stored word (read-first)
//
// Ports:
//   CLK      in   rising-edge clock
//   RST_N    in   asynchronous active-low reset
//   wr_en    in   write strobe
//   wr_addr  in   {bank, row} write address
//   wr_data  in   write word
//   rd_en    in   read strobe
//   rd_addr  in   {bank, row} read address
//   clr      in   full-array clear request (single-cycle pulse)
//   Q        out  registered read data
//   Q_valid  out  Q was updated by a read accepted on the last edge
//   ready    out  array accessible (clear sweep finished)
// ---------------------------------------------------------------------------
module banked_mat_ram #(
  parameter int  ADDR_LEN  = 6,
  parameter int  DATA_LEN  = 8,
  parameter int  NUM_BANKS = 4,
  localparam int BANK_BITS = $clog2(NUM_BANKS)
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          wr_en,
  input  logic [BANK_BITS+ADDR_LEN-1:0] wr_addr,
  input  logic [DATA_LEN-1:0]           wr_data,
  input  logic                          rd_en,
  input  logic [BANK_BITS+ADDR_LEN-1:0] rd_addr,
  input  logic                          clr,
  output logic [DATA_LEN-1:0]           Q,
  output logic                          Q_valid,
  output logic                          ready
);

  localparam int ROWS = 1 << ADDR_LEN;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  logic                 state;
  logic [ADDR_LEN-1:0]  clr_cnt;

  logic [DATA_LEN-1:0]  mem [NUM_BANKS][ROWS];

  logic [BANK_BITS-1:0] wr_bank;
  logic [ADDR_LEN-1:0]  wr_row;
  logic [BANK_BITS-1:0] rd_bank;
  logic [ADDR_LEN-1:0]  rd_row;

  assign wr_bank = wr_addr[BANK_BITS+ADDR_LEN-1 -: BANK_BITS];
  assign wr_row  = wr_addr[ADDR_LEN-1:0];
  assign rd_bank = rd_addr[BANK_BITS+ADDR_LEN-1 -: BANK_BITS];
  assign rd_row  = rd_addr[ADDR_LEN-1:0];

  assign ready = (state == ST_RUN);

  // Clear sequencer. The row counter only advances while clearing and
  // naturally wraps back to 0 on the last row, so it is already at row 0
  // whenever a new clear sweep starts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) begin
        state <= ST_RUN;
      end
    end else if (clr) begin
      state <= ST_CLEAR;
    end
  end

  // Storage array, deliberately not reset. A write in the same cycle as a
  // clr request still lands here; the following sweep then erases it.
  always_ff @(posedge CLK) begin
    if (state == ST_CLEAR) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        mem[b[BANK_BITS-1:0]][clr_cnt] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_bank][wr_row] <= wr_data;
    end
  end

  // Registered read port. Q holds across idle cycles and during a clear;
  // Q_valid marks only the cycle after an accepted read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q       <= '0;
      Q_valid <= 1'b0;
    end else begin
      Q_valid <= 1'b0;
      if ((state == ST_RUN) && rd_en) begin
        Q_valid <= 1'b1;
`ifdef MATRAM_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr)) begin
          Q <= wr_data;
        end else begin
          Q <= mem[rd_bank][rd_row];
        end
`else
        Q <= mem[rd_bank][rd_row];
`endif
      end
    end
  end

endmodule

// File: tb/tb_banked_mat_ram.sv
// ---------------------------------------------------------------------------
// tb_banked_mat_ram
//
// Self-checking bench for banked_mat_ram with default parameters
// (4 banks x 64 rows x 8 bits, flat 8-bit address = bank*64 + row).
// A flat 256-entry array serves as the reference memory; the expected read
// word, valid flag and clear duration are derived from it and from the
// documented timing rules.
// ---------------------------------------------------------------------------
module tb_banked_mat_ram;

  logic       CLK;
  logic       RST_N;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic       clr;
  logic [7:0] Q;
  logic       Q_valid;
  logic       ready;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model [256];
  logic [7:0] exp_q;

  banked_mat_ram dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .clr     (clr),
    .Q       (Q),
    .Q_valid (Q_valid),
    .ready   (ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Count edges until ready rises, bounded so a stuck design still finishes.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (!ready && edges < 200) begin
      step();
      edges++;
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  task automatic test_reset();
    int n;
    RST_N = 1'b0; idle_inputs();
    wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00;
    #3;
    checks++;
    if (Q !== 8'h00) begin failures++; $display("[TB] FAIL reset_q Q=%h expected 00", Q); end
    checks++;
    if (Q_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_qvalid got %b expected 0", Q_valid); end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got %b expected 0", ready); end
    step(); step();
    RST_N = 1'b1;
    wait_ready(n);
    checks++;
    if (n !== 64) begin failures++; $display("[TB] FAIL reset_clear_time edges=%0d expected 64", n); end
    model_clear();
    exp_q = 8'h00;
  endtask

  task automatic test_read_all_zero();
    for (int a = 0; a < 256; a++) begin
      rd_en = 1'b1; rd_addr = 8'(a);
      step();
      checks++;
      if (Q !== model[a] || Q_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL read_zero addr=%0d Q=%h Q_valid=%b expected %h/1", a, Q, Q_valid, model[a]);
      end
    end
    rd_en = 1'b0;
    exp_q = 8'h00;
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 8'd145; wr_data = 8'hA5;
    step();
    model[145] = 8'hA5;
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'd145;
    step();
    checks++;
    if (Q !== 8'hA5 || Q_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL write_read Q=%h Q_valid=%b expected a5/1", Q, Q_valid);
    end
    rd_addr = 8'd81;
    step();
    checks++;
    if (Q !== 8'h00 || Q_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL bank_isolation Q=%h Q_valid=%b expected 00/1", Q, Q_valid);
    end
    rd_en = 1'b0;
    exp_q = 8'h00;
  endtask

  task automatic test_same_cycle();
    logic [7:0] want;
    wr_en = 1'b1; wr_addr = 8'h45; wr_data = 8'h11;
    step();
    wr_data = 8'h3C; rd_en = 1'b1; rd_addr = 8'h45;
`ifdef MATRAM_BYPASS_EN
    want = 8'h3C;
`else
    want = 8'h11;
`endif
    step();
    checks++;
    if (Q !== want || Q_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL same_cycle Q=%h Q_valid=%b expected %h/1", Q, Q_valid, want);
    end
    wr_en = 1'b0;
    step();
    checks++;
    if (Q !== 8'h3C || Q_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL same_cycle_after Q=%h Q_valid=%b expected 3c/1", Q, Q_valid);
    end
    model[8'h45] = 8'h3C;
    rd_en = 1'b0;
    exp_q = 8'h3C;
  endtask

  task automatic test_rd_pulse();
    wr_en = 1'b1; wr_addr = 8'd10; wr_data = 8'h12;
    step();
    wr_addr = 8'd20; wr_data = 8'h34;
    step();
    model[10] = 8'h12; model[20] = 8'h34;
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'd10;
    step();
    checks++;
    if (Q !== 8'h12 || Q_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL pulse_1 Q=%h Q_valid=%b expected 12/1", Q, Q_valid);
    end
    rd_en = 1'b0; rd_addr = 8'd20;
    step();
    checks++;
    if (Q !== 8'h12 || Q_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL pulse_gap Q=%h Q_valid=%b expected 12/0", Q, Q_valid);
    end
    rd_en = 1'b1;
    step();
    checks++;
    if (Q !== 8'h34 || Q_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL pulse_2 Q=%h Q_valid=%b expected 34/1", Q, Q_valid);
    end
    rd_en = 1'b0;
    exp_q = 8'h34;
  endtask

  task automatic test_random();
    logic exp_v;
    for (int c = 0; c < 400; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = 8'($urandom_range(0, 255));
      wr_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 8'($urandom_range(0, 255));
      wr_data = 8'($urandom_range(0, 255));
      exp_v = rd_en;
      if (rd_en) begin
`ifdef MATRAM_BYPASS_EN
        exp_q = (wr_en && wr_addr == rd_addr) ? wr_data : model[rd_addr];
`else
        exp_q = model[rd_addr];
`endif
      end
      if (wr_en) model[wr_addr] = wr_data;
      step();
      checks++;
      if (Q !== exp_q || Q_valid !== exp_v) begin
        failures++;
        $display("[TB] FAIL random cycle=%0d Q=%h Q_valid=%b expected %h/%b", c, Q, Q_valid, exp_q, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clr();
    int n;
    wr_en = 1'b1; wr_data = 8'hFF;
    for (int a = 0; a < 256; a++) begin
      wr_addr = 8'(a);
      step();
      model[a] = 8'hFF;
    end
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'd0;
    step();
    checks++;
    if (Q !== 8'hFF || Q_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL clr_prefill Q=%h Q_valid=%b expected ff/1", Q, Q_valid);
    end
    // clr together with a write: the write lands, then the sweep erases it
    rd_en = 1'b0; clr = 1'b1; wr_en = 1'b1; wr_addr = 8'd3; wr_data = 8'hEE;
    step();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      rd_addr = 8'($urandom_range(0, 255));
      step();
      n++;
      checks++;
      if (Q !== 8'hFF || Q_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL clr_window edge=%0d Q=%h Q_valid=%b expected ff/0", n, Q, Q_valid);
      end
    end
    checks++;
    if (n !== 64) begin failures++; $display("[TB] FAIL clr_time edges=%0d expected 64", n); end
    rd_en = 1'b0;
    model_clear();
    test_read_all_zero();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'h77;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'd5;
    step();
    checks++;
    if (Q !== 8'h77) begin failures++; $display("[TB] FAIL midclr_prefill Q=%h expected 77", Q); end
    rd_en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (30) step();
    RST_N = 1'b0;
    #1;
    checks++;
    if (Q !== 8'h00 || Q_valid !== 1'b0 || ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midclr_reset Q=%h Q_valid=%b ready=%b expected 00/0/0", Q, Q_valid, ready);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    wait_ready(n);
    checks++;
    if (n !== 64) begin failures++; $display("[TB] FAIL midclr_time edges=%0d expected 64", n); end
    model_clear();
    rd_en = 1'b1; rd_addr = 8'd5;
    step();
    checks++;
    if (Q !== 8'h00 || Q_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL midclr_read Q=%h Q_valid=%b expected 00/1", Q, Q_valid);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_all_zero();
    test_write_read();
    test_same_cycle();
    test_rd_pulse();
    test_random();
    test_clr();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
